// File: rtl/seq_lsam_mul_ctrl.sv
// Sequential 8x8 multiplier: one shared 4x4 nibble multiplier, four steps per operation.
// Build option LSAM_EXACT_EN selects an exact nibble product instead of the approximate one.
module seq_lsam_mul_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_p,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [7:0]       a_q, b_q;
  logic [15:0]      acc_q;
  logic [15:0]      pp_d, pp_p1;
  logic             vld_d, vld_p1;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, retire;
  logic [3:0]       nib_x, nib_y;
  logic [3:0]       pp_sh;

  function automatic logic [7:0] nib_mul(input logic [3:0] x, input logic [3:0] y);
`ifdef LSAM_EXACT_EN
    nib_mul = {4'd0, x} * {4'd0, y};
`else
    // y[3] is deliberately dropped; y[2] is weighted as 3 instead of 4.
    nib_mul = ({4'd0, x} * {6'd0, y[1:0]}) + ({4'd0, x} * (y[2] ? 8'd3 : 8'd0));
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    retire    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept  = 1'b1;
          step_d  = 3'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        // Step 4 only drains the last registered partial product.
        if (step_q == 3'd4) begin
          state_d = DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          retire  = 1'b1;
          step_d  = 3'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 3'd0;
      end
    endcase
  end

  always_comb begin
    nib_x = a_q[3:0];
    nib_y = b_q[3:0];
    pp_sh = 4'd0;
    case (step_q[1:0])
      2'd0: begin nib_x = a_q[3:0]; nib_y = b_q[3:0]; pp_sh = 4'd0; end
      2'd1: begin nib_x = a_q[7:4]; nib_y = b_q[3:0]; pp_sh = 4'd4; end
      2'd2: begin nib_x = a_q[3:0]; nib_y = b_q[7:4]; pp_sh = 4'd4; end
      default: begin nib_x = a_q[7:4]; nib_y = b_q[7:4]; pp_sh = 4'd8; end
    endcase
    pp_d  = {8'd0, nib_mul(nib_x, nib_y)} << pp_sh;
    vld_d = (state_q == MUL) && (step_q != 3'd4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      vld_p1  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      vld_p1  <= vld_d;
      if (retire) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // p0 -> p1: operands latched on accept, partial product registered each MUL step
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
    end
    pp_p1 <= pp_d;
  end

  // p1 -> accumulator: modulo-2^16 accumulate of the registered partial product
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      acc_q <= 16'd0;
    end else if (vld_p1) begin
      acc_q <= acc_q + pp_p1;
    end
  end

  assign out_p  = acc_q;
  assign op_cnt = cnt_q;

endmodule

// File: tb/tb_seq_lsam_mul_ctrl.sv
// Directed bench for seq_lsam_mul_ctrl (CNT_W=2); expectations follow LSAM_EXACT_EN when defined.
module tb_seq_lsam_mul_ctrl;

  localparam int CNT_W = 2;
`ifdef LSAM_EXACT_EN
  localparam bit EXACT = 1'b1;
`else
  localparam bit EXACT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_p;
  logic             busy;
  logic [CNT_W-1:0] op_cnt;

  seq_lsam_mul_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy),
    .op_cnt    (op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p_apx;
    logic [15:0] p_ex;
  } vec_t;

  vec_t             vecs [7];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Caller is positioned 1 time unit after a rising edge with DUT in IDLE and out_ready=1.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                        input string name);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = 8'h5A;
    in_b     = 8'hC3;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd5);
    chk({name, "_out_p"}, 32'(out_p), 32'(exp_p));
    chk({name, "_busy"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1'b1;
    chk({name, "_out_valid_off"}, 32'(out_valid), 32'd0);
    chk({name, "_op_cnt"}, 32'(op_cnt), 32'(exp_cnt));
    chk({name, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    vecs[0] = '{8'h11, 8'h11, 16'h0121, 16'h0121};
    vecs[1] = '{8'hFF, 8'hFF, 16'h659A, 16'hFE01};
    vecs[2] = '{8'h0F, 8'h08, 16'h0000, 16'h0078};
    vecs[3] = '{8'h23, 8'h12, 16'h0276, 16'h0276};
    vecs[4] = '{8'hA5, 8'h64, 16'h357F, 16'h4074};
    vecs[5] = '{8'hFF, 8'h01, 16'h00FF, 16'h00FF};
    vecs[6] = '{8'h80, 8'h80, 16'h0000, 16'h4000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b1;
    exp_cnt   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    chk("rst_op_cnt", 32'(op_cnt), 32'd0);
    rst = 1'b0;

    // Reset lands while step2 is in flight.
    in_valid = 1'b1;
    in_a     = 8'h11;
    in_b     = 8'h11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_p", 32'(out_p), 32'd0);
    chk("midrst_op_cnt", 32'(op_cnt), 32'd0);
    run_op(8'h11, 8'h11, 16'h0121, "post_rst");

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    chk("rst2_op_cnt", 32'(op_cnt), 32'd0);

    // Back-to-back ops; op_cnt walks 1,2,3,0,1,2,3 with CNT_W=2.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, EXACT ? vecs[i].p_ex : vecs[i].p_apx, $sformatf("vec%0d", i));
    end

    // Consumer stalls in DONE while new operands are offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'h11;
    in_b      = 8'h11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_latency", 32'(n), 32'd5);
    in_valid = 1'b1;
    in_a     = 8'hFF;
    in_b     = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_out_p", k), 32'(out_p), 32'h0121);
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1'b1;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);
    chk("release_op_cnt", 32'(op_cnt), 32'(exp_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_lsam_mul_ctrl.md
SEQ_LSAM_MUL_CTRL -- requirements
Module: seq_lsam_mul_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  controller accepts operands.
REQ-006 SHALL have port: in_a  input  8  multiplicand.
REQ-007 SHALL have port: in_b  input  8  multiplier.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: out_p  output  16  product.
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port: op_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-013 SHALL time-share one internal 4x4 nibble multiplier across four steps per 8x8 operation.
REQ-014 SHALL define the approximate nibble product of x,y (4-bit) as x*y[1:0] + x*(3*y[2]), 8-bit result, y[3] ignored.
REQ-015 SHALL implement FSM states IDLE, MUL, DONE; reset state IDLE.
REQ-016 SHALL assert in_ready only in IDLE; an accept is in_valid && in_ready at a rising edge.
REQ-017 SHALL, on accept, register in_a/in_b, clear the 16-bit accumulator, set step=0, enter MUL.
REQ-018 SHALL, in MUL, process one step per cycle in order: step0 a_lo*b_lo shift 0; step1 a_hi*b_lo shift 4; step2 a_lo*b_hi shift 4; step3 a_hi*b_hi shift 8.
REQ-019 SHALL add each shifted partial product into the accumulator modulo 2^16.
REQ-020 SHALL enter DONE after step3, giving out_valid high exactly 5 rising edges after the accepting edge.
REQ-021 SHALL drive out_p from the accumulator and hold it and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL, on out_valid && out_ready, return to IDLE and increment op_cnt, wrapping from 2^CNT_W-1 to 0.
REQ-023 SHALL ignore in_valid and operand changes outside IDLE; a new op is accepted no earlier than the edge after DONE exits.

Reset
REQ-024 SHALL, when rst is high at a rising edge, force IDLE, in_ready=1 after the edge, out_valid=0, busy=0, out_p=0, op_cnt=0, step=0, accumulator=0.
REQ-025 SHALL give rst priority over every handshake; an in-flight operation is discarded and not counted.

Configuration
REQ-026 SHALL honour macro LSAM_EXACT_EN: defined -> nibble product is exact x*y and out_p equals in_a*in_b; undefined -> REQ-014 approximation; sequencing, latency and handshakes identical in both builds.

Verification
REQ-027 SHALL cover: a=0x11, b=0x11, out_ready=1 -> out_p=0x0121 in both builds, out_valid 5 edges after accept, op_cnt=1.
REQ-028 SHALL cover: a=0xFF, b=0xFF -> out_p=0x659A without LSAM_EXACT_EN, 0xFE01 with it.
REQ-029 SHALL cover: a=0x0F, b=0x08 -> out_p=0x0000 approximate (b[3] dropped), 0x0078 exact.
REQ-030 SHALL cover: out_ready held low 3 cycles in DONE, in_valid=1 with new operands -> out_p and out_valid stable, in_ready=0, new operands not captured; release -> IDLE next edge.
REQ-031 SHALL cover: rst asserted during MUL step2 -> next edge IDLE, out_valid=0, op_cnt unchanged, a following op a=0x11, b=0x11 yields 0x0121.
REQ-032 SHALL cover: CNT_W=2, five back-to-back operations -> op_cnt sequence 1,2,3,0,1.
